// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } loader_state_t;

  localparam int          BYTE_WIDTH_DEF = 8;
  localparam int          DATA_WIDTH_DEF = 32;
  localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
  localparam int          BYTES_PER_WORD = DATA_WIDTH_DEF / BYTE_WIDTH_DEF;

  // Running frame checksum: XOR of every payload byte.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/uart_program_loader.sv
// Decodes a framed program image from the UART receiver, packs payload bytes
// little-endian into memory words, writes them to instruction memory and
// releases the core from reset only after a frame with a good checksum.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int         BYTE_WIDTH     = 8,
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 8,
  parameter logic [7:0] SYNC           = SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx_done,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic                  core_hold
);

  localparam int BPW    = DATA_WIDTH / BYTE_WIDTH;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  loader_state_t          state_r;
  logic [BIDX_W-1:0]      byte_idx_r;
  logic [ADDR_WIDTH-1:0]  word_idx_r;
  logic [BYTE_WIDTH-1:0]  count_r;
  logic [7:0]             chk_r;
  logic [TMO_W-1:0]       tmo_r;
  logic [DATA_WIDTH-1:0]  word_r;
  logic                   mem_we_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic [DATA_WIDTH-1:0]  mem_wdata_r;
  logic                   load_done_r;
  logic                   load_error_r;
  logic                   core_hold_r;

  logic                   tmo_hit_s;
  logic                   last_byte_s;
  logic                   last_word_s;
  logic [DATA_WIDTH-1:0]  word_next_s;

  // Frame-level decode helpers derived from the current registers and input byte.
  always_comb begin
    tmo_hit_s   = (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
    last_byte_s = (byte_idx_r == BIDX_W'(BPW - 1));
    last_word_s = (word_idx_r == ADDR_WIDTH'(count_r - {{(BYTE_WIDTH-1){1'b0}}, 1'b1}));
    // First byte received ends up in the least-significant lane after BPW shifts.
    word_next_s = {rx_data, word_r[DATA_WIDTH-1:BYTE_WIDTH]};
  end

  // Loader FSM with word packer, checksum, inter-byte timeout and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r      <= IDLE;
      byte_idx_r   <= '0;
      word_idx_r   <= '0;
      count_r      <= '0;
      chk_r        <= 8'h00;
      tmo_r        <= '0;
      word_r       <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
      core_hold_r  <= 1'b1;
    end else begin
      mem_we_r    <= 1'b0;
      load_done_r <= 1'b0;
      if ((state_r != IDLE) && !rx_done) begin
        // Waiting for the next byte inside a frame.
        if (tmo_hit_s) begin
          load_error_r <= 1'b1;
          state_r      <= IDLE;
          tmo_r        <= '0;
        end else begin
          tmo_r <= tmo_r + TMO_W'(1);
        end
      end else begin
        tmo_r <= '0;
        case (state_r)
          IDLE: begin
            if (rx_done && (rx_data == SYNC)) begin
              state_r      <= COUNT;
              load_error_r <= 1'b0;
              core_hold_r  <= 1'b1;
              chk_r        <= 8'h00;
              byte_idx_r   <= '0;
              word_idx_r   <= '0;
              count_r      <= '0;
              word_r       <= '0;
            end else begin
              state_r <= IDLE;
            end
          end
          COUNT: begin
            if (rx_data == '0) begin
              load_error_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              count_r <= rx_data;
              state_r <= DATA;
            end
          end
          DATA: begin
            word_r <= word_next_s;
            chk_r  <= chk_update(chk_r, rx_data);
            if (last_byte_s) begin
              mem_wdata_r <= word_next_s;
              mem_addr_r  <= word_idx_r;
              mem_we_r    <= 1'b1;
              byte_idx_r  <= '0;
              word_idx_r  <= word_idx_r + ADDR_WIDTH'(1);
              if (last_word_s) begin
                state_r <= CHECK;
              end else begin
                state_r <= DATA;
              end
            end else begin
              byte_idx_r <= byte_idx_r + BIDX_W'(1);
            end
          end
          CHECK: begin
            state_r <= IDLE;
            if (rx_data == chk_r) begin
              load_done_r <= 1'b1;
              core_hold_r <= 1'b0;
            end else begin
              load_error_r <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign load_busy  = (state_r != IDLE);
  assign load_done  = load_done_r;
  assign load_error = load_error_r;
  assign core_hold  = core_hold_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected memory writes are queued
// as frames are sent and popped when the loader issues mem_we.
module tb_uart_program_loader;

  logic        clk;
  logic        arst_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic        core_hold;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;

  uart_program_loader #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_error (load_error),
    .core_hold  (core_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: compares every write against the scoreboard and counts done pulses.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_we", {56'd0, mem_addr}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", {56'd0, mem_addr}, {56'd0, e.addr});
        check_val("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
      end
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  // Sends SYNC, N, the words in words_q (LSB first) and XOR checksum ^ chk_mask.
  task automatic send_frame(input int n, input logic [7:0] chk_mask);
    logic [7:0]  chk;
    logic [31:0] w;
    chk = 8'h00;
    send_byte(8'hA5);
    check_val("sync_err_clr", {63'd0, load_error}, 64'd0);
    check_val("sync_busy",    {63'd0, load_busy},  64'd1);
    check_val("sync_hold",    {63'd0, core_hold},  64'd1);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      exp_q.push_back('{addr: 8'(i), data: w});
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        chk = chk ^ w[8*b +: 8];
      end
    end
    send_byte(chk ^ chk_mask);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_we"},    {63'd0, mem_we},     64'd0);
    check_val({tag, "_addr"},  {56'd0, mem_addr},   64'd0);
    check_val({tag, "_wdata"}, {32'd0, mem_wdata},  64'd0);
    check_val({tag, "_busy"},  {63'd0, load_busy},  64'd0);
    check_val({tag, "_done"},  {63'd0, load_done},  64'd0);
    check_val({tag, "_err"},   {63'd0, load_error}, 64'd0);
    check_val({tag, "_hold"},  {63'd0, core_hold},  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int d0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    arst_n  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: good two-word frame
    words_q = '{32'h0000_0013, 32'h0010_0093};
    send_frame(2, 8'h00);
    repeat (2) @(negedge clk);
    check_val("t1_done_cnt", 64'(done_cnt), 64'd1);
    check_val("t1_hold",  {63'd0, core_hold},  64'd0);
    check_val("t1_err",   {63'd0, load_error}, 64'd0);
    check_val("t1_busy",  {63'd0, load_busy},  64'd0);
    check_val("t1_q",     64'(exp_q.size()),   64'd0);

    // 2: same frame with corrupted checksum
    send_frame(2, 8'h01);
    repeat (2) @(negedge clk);
    check_val("t2_done_cnt", 64'(done_cnt), 64'd1);
    check_val("t2_err",   {63'd0, load_error}, 64'd1);
    check_val("t2_hold",  {63'd0, core_hold},  64'd1);
    check_val("t2_q",     64'(exp_q.size()),   64'd0);

    // 3: zero word count
    send_byte(8'hA5);
    send_byte(8'h00);
    @(negedge clk);
    check_val("t3_err",  {63'd0, load_error}, 64'd1);
    check_val("t3_busy", {63'd0, load_busy},  64'd0);

    // 4: noise bytes, then a one-word frame
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    check_val("t4_noise_busy", {63'd0, load_busy}, 64'd0);
    words_q = '{32'h1234_5678};
    send_frame(1, 8'h00);
    repeat (2) @(negedge clk);
    check_val("t4_done_cnt", 64'(done_cnt), 64'd2);
    check_val("t4_hold", {63'd0, core_hold},  64'd0);
    check_val("t4_err",  {63'd0, load_error}, 64'd0);

    // 5: inter-byte timeout mid-word
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hAA);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (load_error === 1'b1) break;
    end
    check_val("t5_tmo_cycles", 64'(cyc), 64'd100);
    check_val("t5_err",  {63'd0, load_error}, 64'd1);
    check_val("t5_busy", {63'd0, load_busy},  64'd0);
    check_val("t5_hold", {63'd0, core_hold},  64'd1);

    // 6: reset mid-frame, then a good frame with random words
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    arst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    words_q = '{$urandom(), $urandom(), $urandom()};
    send_frame(3, 8'h00);
    repeat (2) @(negedge clk);
    check_val("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_val("t6_hold", {63'd0, core_hold},  64'd0);
    check_val("t6_err",  {63'd0, load_error}, 64'd0);
    check_val("t6_q",    64'(exp_q.size()),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
